mole_scheduler: RTL and testbench

- Consumes the 8-bit pseudo-random byte from the LFSR stage and turns it into game events: which hole a mole pops from, how long it stays up, and the gap before the next spawn.
- Tracks every hole's lifetime, resolves player whacks, and keeps hit/miss tallies for the score display.
- Sits between the random generator and the LED/7-seg output logic.

---
 rtl/mole_scheduler.sv | 157 +++++++++++++++
 tb/tb_mole_scheduler.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_scheduler.sv
`default_nettype none
// =============================================================================
// mole_scheduler: turns LFSR bytes into mole spawns, lifetimes, hit/miss tallies.
// Revision: 1.0
// =============================================================================
module mole_scheduler #(
    parameter int HOLE_BITS  = 3,
    parameter int MAX_ACTIVE = 3,
    parameter int GAP_BASE   = 4,
    parameter int UP_BASE    = 8,
    parameter int CNT_W      = 5
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      enable,
    input  logic                      tick,
    input  logic [7:0]                rand_data,
    input  logic [(2**HOLE_BITS)-1:0] hit,
    output logic [(2**HOLE_BITS)-1:0] moles,
    output logic                      hit_pulse,
    output logic                      miss_pulse,
    output logic [7:0]                score,
    output logic [7:0]                misses
);
    localparam int NUM_HOLES = 2**HOLE_BITS;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_PICK = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     gap, gap_nxt;
    logic [HOLE_BITS-1:0] base, base_nxt;
    logic [HOLE_BITS-1:0] offset, offset_nxt;
    logic [HOLE_BITS-1:0] candidate;
    logic                 spawn;
    logic                 at_cap;
    logic [CNT_W-1:0]     gap_load, life_load;
    logic [CNT_W-1:0]     life [NUM_HOLES];
    logic [NUM_HOLES-1:0] hit_ok, expire;
    logic [8:0]           score_sum, miss_sum;
    logic                 unused_rand;

    // Only some random bits feed hole/gap/life selection for a given HOLE_BITS.
    assign unused_rand = &{1'b0, rand_data};

    assign gap_load  = CNT_W'(GAP_BASE) + CNT_W'(rand_data[7:4]);
    assign life_load = CNT_W'(UP_BASE) + CNT_W'(rand_data[7:5]);
    assign candidate = base + offset;
    assign at_cap    = ($countones(moles) == MAX_ACTIVE);

    // A hit beats an expiry on the same hole in the same cycle.
    assign hit_ok = moles & hit;
    always_comb begin
        expire = '0;
        for (int i = 0; i < NUM_HOLES; i++) begin
            expire[i] = moles[i] & tick & ~hit[i] & (life[i] == CNT_W'(1));
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state  <= S_IDLE;
            gap    <= '0;
            base   <= '0;
            offset <= '0;
        end else begin
            state  <= state_nxt;
            gap    <= gap_nxt;
            base   <= base_nxt;
            offset <= offset_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        gap_nxt    = gap;
        base_nxt   = base;
        offset_nxt = offset;
        spawn      = 1'b0;
        if (!enable) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    gap_nxt   = gap_load;
                    state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    if (tick) begin
                        if (gap > CNT_W'(1)) begin
                            gap_nxt = gap - CNT_W'(1);
                        end else begin
                            state_nxt  = S_PICK;
                            base_nxt   = rand_data[HOLE_BITS-1:0];
                            offset_nxt = '0;
                        end
                    end
                end
                S_PICK: begin
                    // Probing walks one hole per cycle and needs no tick.
                    if (!at_cap) begin
                        if (!moles[candidate]) begin
                            spawn     = 1'b1;
                            gap_nxt   = gap_load;
                            state_nxt = S_WAIT;
                        end else begin
                            offset_nxt = offset + HOLE_BITS'(1);
                        end
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            moles <= '0;
            for (int i = 0; i < NUM_HOLES; i++) begin
                life[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_HOLES; i++) begin
                if (hit_ok[i] || expire[i]) begin
                    moles[i] <= 1'b0;
                    life[i]  <= '0;
                end else if (spawn && (candidate == HOLE_BITS'(i))) begin
                    moles[i] <= 1'b1;
                    life[i]  <= life_load;
                end else if (moles[i] && tick) begin
                    life[i] <= life[i] - CNT_W'(1);
                end
            end
        end
    end

    assign score_sum = {1'b0, score}  + 9'($countones(hit_ok));
    assign miss_sum  = {1'b0, misses} + 9'($countones(expire));

    always_ff @(posedge clock) begin
        if (!resetn) begin
            score      <= '0;
            misses     <= '0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
        end else begin
            score      <= score_sum[8] ? 8'hFF : score_sum[7:0];
            misses     <= miss_sum[8]  ? 8'hFF : miss_sum[7:0];
            hit_pulse  <= |hit_ok;
            miss_pulse <= |expire;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mole_scheduler.sv
`default_nettype none
// =============================================================================
// tb_mole_scheduler: directed and randomized checks against a behavioural game model.
// Revision: 1.0
// =============================================================================
module tb_mole_scheduler;
    localparam int HB   = 3;
    localparam int NH   = 8;
    localparam int MAXA = 3;
    localparam int GB   = 4;
    localparam int UB   = 8;
    localparam int CW   = 5;

    logic          clock = 1'b0;
    logic          resetn, enable, tick;
    logic [7:0]    rand_data;
    logic [NH-1:0] hit, moles;
    logic          hit_pulse, miss_pulse;
    logic [7:0]    score, misses;

    int errors = 0;
    int checks = 0;

    // Model state: 0 idle, 1 waiting for gap, 2 picking a hole.
    int m_state, m_gap, m_base, m_off, m_score, m_miss;
    int m_life [NH];
    bit m_up [NH];
    bit m_hp, m_mp;

    mole_scheduler #(
        .HOLE_BITS(HB), .MAX_ACTIVE(MAXA), .GAP_BASE(GB), .UP_BASE(UB), .CNT_W(CW)
    ) dut (
        .clock(clock), .resetn(resetn), .enable(enable), .tick(tick),
        .rand_data(rand_data), .hit(hit), .moles(moles), .hit_pulse(hit_pulse),
        .miss_pulse(miss_pulse), .score(score), .misses(misses)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [NH-1:0] mv();
        logic [NH-1:0] v;
        for (int i = 0; i < NH; i++) v[i] = m_up[i];
        return v;
    endfunction

    function automatic int mcount();
        int n = 0;
        for (int i = 0; i < NH; i++) n += int'(m_up[i]);
        return n;
    endfunction

    task automatic model_step();
        bit old_up [NH];
        int active, hits, exps, cand, gl, ll;
        if (!resetn) begin
            m_state = 0; m_gap = 0; m_base = 0; m_off = 0;
            m_score = 0; m_miss = 0; m_hp = 0; m_mp = 0;
            for (int i = 0; i < NH; i++) begin m_up[i] = 0; m_life[i] = 0; end
            return;
        end
        active = 0; hits = 0; exps = 0;
        gl = GB + int'(rand_data[7:4]);
        ll = UB + int'(rand_data[7:5]);
        for (int i = 0; i < NH; i++) begin
            old_up[i] = m_up[i];
            active += int'(m_up[i]);
        end
        for (int i = 0; i < NH; i++) begin
            if (old_up[i]) begin
                if (hit[i]) begin
                    hits++; m_up[i] = 0; m_life[i] = 0;
                end else if (tick) begin
                    if (m_life[i] == 1) begin exps++; m_up[i] = 0; m_life[i] = 0; end
                    else m_life[i] = m_life[i] - 1;
                end
            end
        end
        if (!enable) begin
            m_state = 0;
        end else if (m_state == 0) begin
            m_gap = gl; m_state = 1;
        end else if (m_state == 1) begin
            if (tick) begin
                if (m_gap > 1) m_gap = m_gap - 1;
                else begin m_state = 2; m_base = int'(rand_data) % NH; m_off = 0; end
            end
        end else begin
            cand = (m_base + m_off) % NH;
            if (active < MAXA) begin
                if (!old_up[cand]) begin
                    m_up[cand] = 1; m_life[cand] = ll; m_gap = gl; m_state = 1;
                end else begin
                    m_off = (m_off + 1) % NH;
                end
            end
        end
        m_score = (m_score + hits > 255) ? 255 : m_score + hits;
        m_miss  = (m_miss + exps > 255) ? 255 : m_miss + exps;
        m_hp = (hits > 0);
        m_mp = (exps > 0);
    endtask

    task automatic step();
        @(posedge clock);
        model_step();
        #1;
        check("moles", moles, mv());
        check("hit_pulse", hit_pulse, m_hp);
        check("miss_pulse", miss_pulse, m_mp);
        check("score", score, m_score);
        check("misses", misses, m_miss);
    endtask

    task automatic do_reset();
        resetn = 0; enable = 0; tick = 0; hit = '0; rand_data = '0;
        step();
        step();
        resetn = 1;
    endtask

    // Long-lived moles, ticks only while waiting, and an enable blip to reload a short gap.
    task automatic drive_cap();
        rand_data = (m_state == 2) ? 8'hE0 : 8'h00;
        enable    = !(m_state == 1 && m_gap > GB);
        tick      = (m_state == 1) && enable;
    endtask

    initial begin
        int pre_s, pre_m;
        bit found;

        do_reset();
        check("rst_moles", moles, 0);
        check("rst_score", score, 0);
        check("rst_misses", misses, 0);

        rand_data = 8'h00; tick = 1; enable = 1;
        for (int c = 1; c <= 15; c++) begin
            step();
            if (c == 5) check("pre_spawn", moles, 8'h00);
            if (c == 6) check("first_spawn", moles, 8'h01);
            if (c == 12) check("probe_spawn", moles, 8'h03);
            if (c == 14) begin
                check("expire_moles", moles, 8'h02);
                check("expire_pulse", miss_pulse, 1);
                check("expire_count", misses, 1);
            end
            if (c == 15) check("miss_pulse_width", miss_pulse, 0);
        end

        do_reset();
        found = 0;
        for (int c = 0; c < 60 && !found; c++) begin
            drive_cap(); step();
            if (mcount() == MAXA) found = 1;
        end
        check("cap_reached", found, 1);
        check("cap_moles", moles, 8'h07);
        for (int c = 0; c < 20 && m_state != 2; c++) begin drive_cap(); step(); end
        for (int c = 0; c < 3; c++) begin
            drive_cap(); step();
            check("cap_hold", moles, 8'h07);
        end
        pre_s = m_score;
        drive_cap(); hit = 8'h02; step(); hit = '0;
        check("release_moles", moles, 8'h05);
        check("release_hit_pulse", hit_pulse, 1);
        check("release_score", score, pre_s + 1);
        drive_cap(); step();
        check("no_same_cycle_reuse", moles, 8'h05);
        check("hit_pulse_width", hit_pulse, 0);
        drive_cap(); step();
        check("respawn", moles, 8'h07);
        pre_s = m_score;
        drive_cap(); hit = 8'h06; step(); hit = '0;
        check("multi_hit_score", score, pre_s + 2);
        check("multi_hit_moles", moles, 8'h01);

        do_reset();
        found = 0;
        enable = 1; tick = 1;
        for (int c = 0; c < 80 && !found; c++) begin
            rand_data = (m_state == 2) ? 8'hE0 : 8'h00;
            if (m_up[0] && m_life[0] == 1) begin
                pre_s = m_score; pre_m = m_miss;
                hit = 8'h01; step(); hit = '0;
                check("tie_score", score, pre_s + 1);
                check("tie_misses", misses, pre_m);
                check("tie_miss_pulse", miss_pulse, 0);
                check("tie_moles", moles, 8'h00);
                found = 1;
            end else begin
                step();
            end
        end
        check("tie_reached", found, 1);

        do_reset();
        enable = 1; tick = 1; rand_data = 8'h00;
        for (int c = 0; c < 20 && !m_up[0]; c++) step();
        enable = 0;
        for (int c = 0; c < 12; c++) step();
        check("disabled_moles", moles, 8'h00);
        check("disabled_misses", misses, 1);

        do_reset();
        enable = 1; tick = 1; rand_data = 8'h00;
        for (int c = 0; c < 3000 && m_score < 255; c++) begin
            hit = mv(); step();
        end
        for (int c = 0; c < 12; c++) begin hit = mv(); step(); end
        check("sat_score", score, 255);
        hit = '0;
        for (int c = 0; c < 8; c++) step();
        resetn = 0; step(); step();
        check("midgame_rst_moles", moles, 0);
        check("midgame_rst_score", score, 0);
        check("midgame_rst_misses", misses, 0);
        check("midgame_rst_pulses", {hit_pulse, miss_pulse}, 0);
        resetn = 1;

        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rand_data = 8'($urandom);
            tick   = ($urandom_range(0, 2) != 0);
            enable = ($urandom_range(0, 19) != 0);
            resetn = ($urandom_range(0, 499) != 0);
            for (int i = 0; i < NH; i++) hit[i] = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
